// File: rtl/lsu_dword_sequencer_pkg.sv
// Shared LSU sequencer definitions: state encoding, dword indexing helpers.
package lsu_dword_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam int NUM_DWORDS  = 4;
    localparam int IDX_W       = 2;
    localparam int DWORD_BYTES = 4;
    localparam int DWORD_W     = 32;

    typedef logic [IDX_W-1:0]      dw_idx_t;
    typedef logic [NUM_DWORDS-1:0] dw_mask_t;

    // Extract dword idx from a packed 4-dword vector
    function automatic logic [DWORD_W-1:0] dword_of(
        input logic [NUM_DWORDS*DWORD_W-1:0] data,
        input dw_idx_t                       idx
    );
        return data[idx*DWORD_W +: DWORD_W];
    endfunction

    // One-hot mask bit for a dword index
    function automatic dw_mask_t dw_onehot(input dw_idx_t idx);
        return dw_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/lsu_dword_sequencer_lowest_bit_sel.sv
// Lowest-set-bit selector: 4-bit dword mask -> index of lowest set bit plus any-set flag.
module lsu_lowest_bit_sel
    import lsu_dword_sequencer_pkg::*;
(
    input  logic [NUM_DWORDS-1:0] i_mask,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_any
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        o_idx = '0;
        o_any = |i_mask;
        for (int i = NUM_DWORDS - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lsu_dword_sequencer.sv
// LSU dword sequencer: turns one decoded op (per-dword rd/wr masks) into a
// series of single-dword memory transactions, lowest enabled dword first,
// writes load data back to the register file and pulses done per op.
// Optional build macro LSU_SEQ_TIMEOUT_EN adds an ack-timeout counter and the
// sticky out_timeout output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a new op (out_ready=1)
// REQ     | memory request for dword r_idx outstanding, waiting for ack
// DONE    | one-cycle done pulse; final load write-back lands here too
module lsu_dword_sequencer
    import lsu_dword_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 12,
    parameter int WFID_W = 6
`ifdef LSU_SEQ_TIMEOUT_EN
    ,
    parameter int TMO_MAX = 255
`endif
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WFID_W-1:0] in_wfid,
    input  logic [3:0]        in_rd_en,
    input  logic [3:0]        in_wr_en,
    input  logic [ADDR_W-1:0] in_base_addr,
    input  logic [REG_W-1:0]  in_lddst_stsrc_addr,
    input  logic [127:0]      in_store_data,
    output logic              out_ready,
    output logic              out_mem_req,
    output logic              out_mem_wr,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [31:0]       out_mem_wdata,
    input  logic              in_mem_ack,
    input  logic [31:0]       in_mem_rdata,
    output logic              out_rf_wr_en,
    output logic [REG_W-1:0]  out_rf_addr,
    output logic [31:0]       out_rf_data,
    output logic              out_done,
    output logic [WFID_W-1:0] out_done_wfid
`ifdef LSU_SEQ_TIMEOUT_EN
    ,
    output logic              out_timeout
`endif
);

    seq_state_t          r_state;
    logic                r_ready;
    dw_mask_t            r_mask;
    logic                r_is_wr;
    dw_idx_t             r_idx;
    logic [ADDR_W-1:0]   r_base;
    logic [REG_W-1:0]    r_lddst;
    logic [127:0]        r_store_data;
    logic [WFID_W-1:0]   r_wfid;

    logic                r_mem_req;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_rf_wr_en;
    logic [REG_W-1:0]    r_rf_addr;
    logic [31:0]         r_rf_data;
    logic                r_done;
    logic [WFID_W-1:0]   r_done_wfid;

`ifdef LSU_SEQ_TIMEOUT_EN
    logic [7:0]          r_tmo_cnt;
    logic                r_timeout;
`endif

    logic                w_in_is_wr;
    dw_mask_t            w_in_mask;
    dw_mask_t            w_sel_mask;
    dw_idx_t             w_idx;
    logic                w_any;
    logic                w_nxt_is_wr;
    logic [ADDR_W-1:0]   w_src_base;
    logic [127:0]        w_src_data;
    logic [ADDR_W-1:0]   w_nxt_addr;
    logic [31:0]         w_nxt_wdata;

    // A store mask, when present, overrides any load mask on the same op
    assign w_in_is_wr = |in_wr_en;
    assign w_in_mask  = w_in_is_wr ? in_wr_en : in_rd_en;

    // Selector sees the incoming mask when idle, otherwise the mask with the
    // in-flight dword removed, so the next request is ready on the ack edge
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_sel_mask  = w_in_mask;
            w_nxt_is_wr = w_in_is_wr;
            w_src_base  = in_base_addr;
            w_src_data  = in_store_data;
        end else begin
            w_sel_mask  = r_mask & ~dw_onehot(r_idx);
            w_nxt_is_wr = r_is_wr;
            w_src_base  = r_base;
            w_src_data  = r_store_data;
        end
    end

    lsu_lowest_bit_sel u_sel (
        .i_mask (w_sel_mask),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_nxt_addr  = w_src_base + ADDR_W'(w_idx) * ADDR_W'(DWORD_BYTES);
    assign w_nxt_wdata = w_nxt_is_wr ? dword_of(w_src_data, w_idx) : 32'h0;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_mask       <= '0;
            r_is_wr      <= 1'b0;
            r_idx        <= '0;
            r_base       <= '0;
            r_lddst      <= '0;
            r_store_data <= '0;
            r_wfid       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_addr    <= '0;
            r_rf_data    <= '0;
            r_done       <= 1'b0;
            r_done_wfid  <= '0;
`ifdef LSU_SEQ_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_rf_wr_en <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_ready) begin
                        r_ready      <= 1'b0;
                        r_mask       <= w_in_mask;
                        r_is_wr      <= w_in_is_wr;
                        r_base       <= in_base_addr;
                        r_lddst      <= in_lddst_stsrc_addr;
                        r_store_data <= in_store_data;
                        r_wfid       <= in_wfid;
                        if (w_any) begin
                            r_state     <= ST_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_wr    <= w_in_is_wr;
                            r_idx       <= w_idx;
                            r_mem_addr  <= w_nxt_addr;
                            r_mem_wdata <= w_nxt_wdata;
`ifdef LSU_SEQ_TIMEOUT_EN
                            r_tmo_cnt   <= '0;
`endif
                        end else begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_done_wfid <= in_wfid;
                        end
                    end
                end
                ST_REQ: begin
                    if (in_mem_ack) begin
                        r_mask <= w_sel_mask;
`ifdef LSU_SEQ_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        if (!r_is_wr) begin
                            r_rf_wr_en <= 1'b1;
                            r_rf_addr  <= r_lddst + REG_W'(r_idx);
                            r_rf_data  <= in_mem_rdata;
                        end
                        if (w_any) begin
                            r_idx       <= w_idx;
                            r_mem_addr  <= w_nxt_addr;
                            r_mem_wdata <= w_nxt_wdata;
                        end else begin
                            r_state     <= ST_DONE;
                            r_mem_req   <= 1'b0;
                            r_done      <= 1'b1;
                            r_done_wfid <= r_wfid;
                        end
                    end
`ifdef LSU_SEQ_TIMEOUT_EN
                    else if (r_tmo_cnt == 8'(TMO_MAX - 1)) begin
                        r_timeout   <= 1'b1;
                        r_mask      <= '0;
                        r_state     <= ST_DONE;
                        r_mem_req   <= 1'b0;
                        r_done      <= 1'b1;
                        r_done_wfid <= r_wfid;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign out_ready     = r_ready;
    assign out_mem_req   = r_mem_req;
    assign out_mem_wr    = r_mem_wr;
    assign out_mem_addr  = r_mem_addr;
    assign out_mem_wdata = r_mem_wdata;
    assign out_rf_wr_en  = r_rf_wr_en;
    assign out_rf_addr   = r_rf_addr;
    assign out_rf_data   = r_rf_data;
    assign out_done      = r_done;
    assign out_done_wfid = r_done_wfid;
`ifdef LSU_SEQ_TIMEOUT_EN
    assign out_timeout   = r_timeout;
`endif

endmodule
